// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: runs mult/div with a fixed busy count, commits to HI/LO; mthi/mtlo write at once.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles, then HI/LO are updated; mthi/mtlo are visible after one edge.
// Backpressure: stall_md holds a D-stage MDU instruction from the start cycle until busy drops; starts while busy are dropped.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [2:0]  op_E,
    input  logic [31:0] srcA_E,
    input  logic [31:0] srcB_E,
    input  logic        md_use_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    hold_hi;
    logic [31:0]    hold_lo;

    logic               is_mul;
    logic               is_div;
    logic               div_zero;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    assign is_mul   = (op_E[2:1] == 2'b00);
    assign is_div   = (op_E[2:1] == 2'b01);
    assign div_zero = (srcB_E == 32'd0);
    assign stall_md = md_use_D & (busy | (start_E & ~op_E[2]));

    // Divisor is forced to 1 on divide-by-zero so the datapath never produces X;
    // that result is discarded in favour of the current HI/LO anyway.
    always_comb begin
        divisor = div_zero ? 32'd1 : srcB_E;
        prod_s  = 64'($signed(srcA_E)) * 64'($signed(srcB_E));
        prod_u  = {32'd0, srcA_E} * {32'd0, srcB_E};
        quot_s  = $signed(srcA_E) / $signed(divisor);
        rem_s   = $signed(srcA_E) % $signed(divisor);
        quot_u  = srcA_E / divisor;
        rem_u   = srcA_E % divisor;
        res_hi  = hi;
        res_lo  = lo;
        case (op_E)
            3'd0: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            3'd1: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            3'd2: if (!div_zero) begin res_hi = rem_s; res_lo = quot_s; end
            3'd3: if (!div_zero) begin res_hi = rem_u; res_lo = quot_u; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hold_hi <= 32'd0;
            hold_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
        end else if (state == IDLE) begin
            if (start_E) begin
                if (is_mul || is_div) begin
                    hold_hi <= res_hi;
                    hold_lo <= res_lo;
                    cnt     <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                    state   <= RUN;
                    busy    <= 1'b1;
                end else if (op_E == 3'd4) begin
                    hi <= srcA_E;
                end else if (op_E == 3'd5) begin
                    lo <= srcA_E;
                end
            end
        end else begin
            if (cnt == '0) begin
                hi    <= hold_hi;
                lo    <= hold_lo;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: table of MDU ops with a scoreboard, plus busy-start and mid-op reset sequences.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start_E;
    logic [2:0]  op_E;
    logic [31:0] srcA_E;
    logic [31:0] srcB_E;
    logic        md_use_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          n;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t sb[$];
    vec_t vec[13];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_E  (start_E),
        .op_E     (op_E),
        .srcA_E   (srcA_E),
        .srcB_E   (srcB_E),
        .md_use_D (md_use_D),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall_md (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where busy is seen low.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int n);
        exp_t e;
        int   cyc;
        e.hi = eh; e.lo = el; e.n = n;
        sb.push_back(e);
        op_E = op; srcA_E = a; srcB_E = b; start_E = 1'b1; md_use_D = 1'b1;
        #1;
        chk("stall_start", {31'd0, stall_md}, (op < 3'd4) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1 start_E = 1'b0;
        cyc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            chk("stall_busy", {31'd0, stall_md}, 32'd1);
        end
        chk("busy_end", {31'd0, busy}, 32'd0);
        e = sb.pop_front();
        chk("busy_cycles", cyc, e.n);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("stall_done", {31'd0, stall_md}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   cyc;

        vec[0]  = '{3'd4, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'h0000_0000, 0};
        vec[1]  = '{3'd5, 32'h0000_5678, 32'h0,         32'h0000_1234, 32'h0000_5678, 0};
        vec[2]  = '{3'd2, 32'h0000_0005, 32'h0,         32'h0000_1234, 32'h0000_5678, 10};
        vec[3]  = '{3'd0, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vec[4]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vec[5]  = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vec[6]  = '{3'd3, 32'h0000_0007, 32'h2,         32'h0000_0001, 32'h0000_0003, 10};
        vec[7]  = '{3'd6, 32'h0000_DEAD, 32'h1,         32'h0000_0001, 32'h0000_0003, 0};
        vec[8]  = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vec[9]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vec[10] = '{3'd3, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 10};
        vec[11] = '{3'd5, 32'hCAFE_BABE, 32'h0,         32'h0000_000F, 32'hCAFE_BABE, 0};
        vec[12] = '{3'd3, 32'h0000_0003, 32'h0,         32'h0000_000F, 32'hCAFE_BABE, 10};

        reset = 1'b0; start_E = 1'b0; op_E = 3'd0; srcA_E = 32'd0; srcB_E = 32'd0; md_use_D = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        md_use_D = 1'b1;
        #1 chk("rst_stall", {31'd0, stall_md}, 32'd0);
        md_use_D = 1'b0; start_E = 1'b1; op_E = 3'd0;
        #1 chk("stall_no_use", {31'd0, stall_md}, 32'd0);
        start_E = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            do_op(vec[i].op, vec[i].a, vec[i].b, vec[i].exp_hi, vec[i].exp_lo, vec[i].n);

        // Starts (mult, then mthi) arriving while busy must be dropped.
        e.hi = 32'd0; e.lo = 32'd15; e.n = 5;
        sb.push_back(e);
        op_E = 3'd0; srcA_E = 32'd3; srcB_E = 32'd5; start_E = 1'b1; md_use_D = 1'b1;
        @(posedge clk);
        #1 start_E = 1'b0;
        cyc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (cyc == 2) begin
                start_E = 1'b1; op_E = 3'd0; srcA_E = 32'd7; srcB_E = 32'd7;
            end else if (cyc == 3) begin
                op_E = 3'd4; srcA_E = 32'h0000_0BAD;
            end else if (cyc == 4) begin
                start_E = 1'b0; md_use_D = 1'b0;
                #1 chk("stall_use_low", {31'd0, stall_md}, 32'd0);
                md_use_D = 1'b1;
            end else begin
                start_E = 1'b0;
            end
        end
        e = sb.pop_front();
        chk("ign_cycles", cyc, e.n);
        chk("ign_hi", hi, e.hi);
        chk("ign_lo", lo, e.lo);

        do_op(3'd4, 32'h0000_0077, 32'h0, 32'h0000_0077, 32'd15, 0);

        // Reset in the third busy cycle of a div discards it.
        op_E = 3'd2; srcA_E = 32'hFFFF_FFF9; srcB_E = 32'd2; start_E = 1'b1; md_use_D = 1'b1;
        @(posedge clk);
        #1 start_E = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_md}, 32'd0);
        repeat (12) @(negedge clk);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage pipeline. Accepts one mult/multu/div/divu/mthi/mtlo request per cycle from the E stage. Runs multi-cycle operations with a fixed latency counter and commits results to the HI/LO registers. Drives the stall request that the hazard logic ORs into Stall_PC_F/Stall_FD/CLR while a D-stage instruction needs the MDU and the MDU is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy duration for div/divu (must be ≥1)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; when 0 at a rising edge all state clears
- start_E  in  1  E-stage instruction is an MDU op this cycle (already qualified by !CLR)
- op_E  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6–7 reserved (no effect)
- srcA_E  in  32  forwarded rs value
- srcB_E  in  32  forwarded rt value
- md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  multi-cycle operation in flight
- stall_md  out  1  combinational: md_use_D & (busy | (start_E & op_E<4))

## Operation
- FSM with two states, IDLE and RUN; reset state is IDLE.
- In IDLE, start_E=1 with op 0–3:
  - Compute the result from srcA_E/srcB_E and latch it into hold registers hold_hi/hold_lo.
  - Load cnt with MULT_CYCLES-1 (mult ops) or DIV_CYCLES-1 (div ops). Go to RUN.
- In RUN:
  - cnt decrements each cycle.
  - On the edge where cnt==0: hi<=hold_hi, lo<=hold_lo, return to IDLE.
- Arithmetic:
  - mult: 64-bit signed product; hi=[63:32], lo=[31:0].
  - multu: same with an unsigned product.
  - div: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (srcB_E==0, div/divu): the op runs the full DIV_CYCLES, then hi/lo keep their prior values.
- mthi/mtlo (op 4/5) in IDLE: hi or lo <= srcA_E at that edge, no busy cycle.
- Any start_E in RUN is ignored; the pipeline stall prevents it. The bench checks that hi/lo/cnt are unaffected.
- Reserved ops: no state change.
- Reset low at any edge, including mid-RUN: state=IDLE, cnt=0, hold_hi/hold_lo/hi/lo=0; the in-flight op is discarded.

## Timing
Reset values: hi=0, lo=0, busy=0; stall_md is 0 whenever md_use_D=0.

- Start sampled at edge T0:
  - busy=1 after edges T0 … T0+N-1, where N is MULT_CYCLES or DIV_CYCLES.
  - hi/lo change and busy=0 after edge T0+N.
- An mfhi/mflo reaching E in the cycle after T0+N reads the new value.
- Default latencies: mult gives 5 busy cycles, div gives 10.
- stall_md is asserted in the start cycle itself (before busy rises), so a following MDU instruction in D is held.
- stall_md stays asserted until the cycle in which busy is 0.
- Back-to-back: a new start_E is accepted in the first cycle busy=0 after completion.
- mthi/mtlo: the write is visible on hi/lo after the sampling edge; busy is never raised.

## Test plan
- mult, srcA=0xFFFFFFFE (-2), srcB=3, MULT_CYCLES=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles; md_use_D=1 throughout gives stall_md=1 from the start cycle through the last busy cycle.
- div, srcA=-7 (0xFFFFFFF9), srcB=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu, srcA=7, srcB=2 -> lo=3, hi=1.
- div by zero after mthi 0x1234 and mtlo 0x5678 -> 10 busy cycles; hi=0x1234 and lo=0x5678 unchanged.
- reset=0 at cycle 3 of a div -> next cycle busy=0, hi=lo=0, stall_md=0.
- start_E mult pulsed again while busy -> ignored; results match the first op only.
